// File: rtl/mcp47feb_dac_sequencer.sv
// mcp47feb_dac_sequencer
//   Arbitrates DAC update requests from two requesters (ch0 -> DAC0 register,
//   ch1 -> DAC1 register) and turns each granted request into one I2C
//   write_multiple-with-stop transaction on the i2c_master command/data
//   streams: the command, then three bytes (register command byte, value
//   high nibble, value low byte). i2c_master runs on clk_25M as well.
//
// Ports
//   clk_25M, rst_p        clock; asynchronous active-high reset
//   chN_req / chN_value   level request held until chN_ack; value sampled at grant
//   chN_ack               1-cycle pulse in the IDLE cycle that grants chN
//   cmd_*                 i2c_master command stream (start/read/write tied 0)
//   data_in*              i2c_master write-data stream
//   i2c_busy              i2c_master busy, waited on after the last byte
//   i2c_missed_ack        i2c_master missed_ack pulse
//   busy                  transaction in progress (any state except IDLE)
//   done                  1-cycle completion pulse, qualified by err_nack/err_timeout
//   nack_count            saturating count of NACKed transactions
//   dbg_state             current FSM state
//
// Handshake: a transfer happens on a clk_25M edge where valid && ready.
// valid, data and last are held stable until that transfer, the only
// exception being a timeout abort, which drops every valid and last at once.
module mcp47feb_dac_sequencer #(
  parameter logic [6:0]  DEV_ADDR = 7'h60,
  parameter logic [4:0]  CH0_REG  = 5'h00,
  parameter logic [4:0]  CH1_REG  = 5'h01,
  parameter int unsigned TIMEOUT  = 20000
) (
  input  logic        clk_25M,
  input  logic        rst_p,
  input  logic        ch0_req,
  input  logic [11:0] ch0_value,
  output logic        ch0_ack,
  input  logic        ch1_req,
  input  logic [11:0] ch1_value,
  output logic        ch1_ack,
  output logic [6:0]  cmd_address,
  output logic        cmd_start,
  output logic        cmd_read,
  output logic        cmd_write,
  output logic        cmd_write_multiple,
  output logic        cmd_stop,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  data_in,
  output logic        data_in_valid,
  input  logic        data_in_ready,
  output logic        data_in_last,
  input  logic        i2c_busy,
  input  logic        i2c_missed_ack,
  output logic        busy,
  output logic        done,
  output logic        err_nack,
  output logic        err_timeout,
  output logic [7:0]  nack_count,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_B0     = 3'd2,
    S_B1     = 3'd3,
    S_B2     = 3'd4,
    S_WAIT   = 3'd5,
    S_REPORT = 3'd6
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_grant;
  logic [11:0] value_q;
  logic [4:0]  reg_q;
  logic [15:0] tmo_cnt;
  logic        nack_flag;
  logic        tmo_flag;
  logic [7:0]  nack_cnt_q;

  logic        req_any;
  logic        grant_ch;
  logic        tmo_hit;
  logic        tmo_abort;

  // Round-robin: with both requesting, the channel not granted last time wins.
  assign req_any  = ch0_req | ch1_req;
  assign grant_ch = (ch0_req && ch1_req) ? ~last_grant : ch1_req;

  // tmo_cnt holds the number of cycles elapsed since the grant (1 in the
  // first CMD cycle), so the abort cycle is TIMEOUT-1 cycles after grant and
  // REPORT lands exactly TIMEOUT cycles after grant.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  assign cmd_start  = 1'b0;
  assign cmd_read   = 1'b0;
  assign cmd_write  = 1'b0;
  assign busy       = (state != S_IDLE);
  assign nack_count = nack_cnt_q;
  assign dbg_state  = state;

  always_ff @(posedge clk_25M or posedge rst_p) begin
    if (rst_p) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      value_q    <= '0;
      reg_q      <= '0;
      tmo_cnt    <= '0;
      nack_flag  <= 1'b0;
      tmo_flag   <= 1'b0;
      nack_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        if (req_any) begin
          last_grant <= grant_ch;
          value_q    <= grant_ch ? ch1_value : ch0_value;
          reg_q      <= grant_ch ? CH1_REG : CH0_REG;
          tmo_cnt    <= 16'd1;
          nack_flag  <= 1'b0;
          tmo_flag   <= 1'b0;
        end
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
        if (i2c_missed_ack) nack_flag <= 1'b1;
        if (tmo_abort) tmo_flag <= 1'b1;
        if (state == S_REPORT && nack_flag && nack_cnt_q != 8'hFF)
          nack_cnt_q <= nack_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    ch0_ack            = 1'b0;
    ch1_ack            = 1'b0;
    cmd_address        = '0;
    cmd_write_multiple = 1'b0;
    cmd_stop           = 1'b0;
    cmd_valid          = 1'b0;
    data_in            = '0;
    data_in_valid      = 1'b0;
    data_in_last       = 1'b0;
    done               = 1'b0;
    err_nack           = 1'b0;
    err_timeout        = 1'b0;
    tmo_abort          = 1'b0;
    case (state)
      S_IDLE: begin
        // The ack is combinational, so it is masked while reset is held.
        if (req_any && !rst_p) begin
          ch0_ack   = ~grant_ch;
          ch1_ack   = grant_ch;
          state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = S_REPORT;
        end else begin
          cmd_valid          = 1'b1;
          cmd_address        = DEV_ADDR;
          cmd_write_multiple = 1'b1;
          cmd_stop           = 1'b1;
          if (cmd_ready) state_nxt = S_B0;
        end
      end
      S_B0: begin
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = S_REPORT;
        end else begin
          data_in       = {reg_q, 2'b00, 1'b0};
          data_in_valid = 1'b1;
          if (data_in_ready) state_nxt = S_B1;
        end
      end
      S_B1: begin
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = S_REPORT;
        end else begin
          data_in       = {4'b0000, value_q[11:8]};
          data_in_valid = 1'b1;
          if (data_in_ready) state_nxt = S_B2;
        end
      end
      S_B2: begin
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = S_REPORT;
        end else begin
          data_in       = value_q[7:0];
          data_in_valid = 1'b1;
          data_in_last  = 1'b1;
          if (data_in_ready) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Timeout takes precedence so a stuck-busy bus is reported as such.
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = S_REPORT;
        end else if (!i2c_busy) begin
          state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        done        = 1'b1;
        err_nack    = nack_flag;
        err_timeout = tmo_flag;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcp47feb_dac_sequencer.sv
// Testbench for mcp47feb_dac_sequencer: directed scenarios plus a randomized
// phase, checked every cycle against a transaction-level model of the
// arbitration and I2C write sequence, with literal expectations on top.
module tb_mcp47feb_dac_sequencer;

  localparam int T = 50;

  // ---------------- clock / reset ----------------
  logic clk_25M = 1'b0;
  logic rst_p;
  always #5 clk_25M = ~clk_25M;

  int cyc = 0;
  always @(posedge clk_25M) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        ch0_req, ch1_req;
  logic [11:0] ch0_value, ch1_value;
  logic        ch0_ack, ch1_ack;
  logic [6:0]  cmd_address;
  logic        cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  data_in;
  logic        data_in_valid, data_in_ready, data_in_last;
  logic        i2c_busy, i2c_missed_ack;
  logic        busy, done, err_nack, err_timeout;
  logic [7:0]  nack_count;
  logic [2:0]  dbg_state;

  mcp47feb_dac_sequencer #(.TIMEOUT(T)) dut (
    .clk_25M(clk_25M), .rst_p(rst_p),
    .ch0_req(ch0_req), .ch0_value(ch0_value), .ch0_ack(ch0_ack),
    .ch1_req(ch1_req), .ch1_value(ch1_value), .ch1_ack(ch1_ack),
    .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
    .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple),
    .cmd_stop(cmd_stop), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_in_last(data_in_last),
    .i2c_busy(i2c_busy), .i2c_missed_ack(i2c_missed_ack),
    .busy(busy), .done(done), .err_nack(err_nack), .err_timeout(err_timeout),
    .nack_count(nack_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // model of the sequencer, one transaction at a time
  bit          m_idle = 1'b1;
  bit          m_report = 1'b0;
  bit          m_nack = 1'b0;
  bit          m_to = 1'b0;
  bit          m_last = 1'b1;
  int          m_item = 0;       // 0 = command, 1..3 = bytes, 4 = waiting for bus idle
  int          m_grant_cyc = 0;
  int          exp_nack_cnt = 0;
  logic [7:0]  exp_q[$];
  int          mon_g;
  int          mon_e;
  logic [11:0] mon_v;
  logic [4:0]  mon_r;

  // observed DUT events, read by the directed tests
  bit          g_log[$];
  logic [8:0]  byte_log[$];      // {last, byte}
  int          act_grant_cyc = 0;
  int          act_done_cyc = 0;
  logic        act_err_nack = 1'b0;
  logic        act_err_to = 1'b0;
  bit          granted_pending[2];

  // ---------------- compare process ----------------
  always @(negedge clk_25M) begin
    if (rst_p) begin
      check("rst_outputs", {busy, cmd_valid, data_in_valid, data_in_last, done,
                            err_nack, err_timeout, ch0_ack, ch1_ack}, 0);
      check("rst_nack_count", nack_count, 0);
      check("rst_dbg_state", dbg_state, 0);
      m_idle = 1'b1; m_report = 1'b0; m_last = 1'b1;
      exp_q.delete();
      exp_nack_cnt = 0;
    end else begin
      if (ch0_ack || ch1_ack) begin
        act_grant_cyc = cyc;
        g_log.push_back(ch1_ack);
      end
      if (data_in_valid && data_in_ready) byte_log.push_back({data_in_last, data_in});
      if (done) begin
        act_done_cyc = cyc;
        act_err_nack = err_nack;
        act_err_to   = err_timeout;
      end

      check("cmd_tieoffs", {cmd_start, cmd_read, cmd_write}, 0);
      check("nack_count", nack_count, exp_nack_cnt);

      if (m_idle) begin
        mon_g = -1;
        if (ch0_req && ch1_req) mon_g = m_last ? 0 : 1;
        else if (ch0_req) mon_g = 0;
        else if (ch1_req) mon_g = 1;
        check("idle_acks", {ch0_ack, ch1_ack}, {mon_g == 0, mon_g == 1});
        check("idle_outputs", {busy, cmd_valid, data_in_valid, data_in_last, done}, 0);
        if (mon_g >= 0) begin
          mon_v = (mon_g == 1) ? ch1_value : ch0_value;
          mon_r = (mon_g == 1) ? 5'h01 : 5'h00;
          exp_q.delete();
          exp_q.push_back({mon_r, 3'b000});
          exp_q.push_back({4'h0, mon_v[11:8]});
          exp_q.push_back(mon_v[7:0]);
          m_last = (mon_g == 1);
          m_idle = 1'b0; m_report = 1'b0; m_nack = 1'b0; m_to = 1'b0;
          m_item = 0;
          m_grant_cyc = cyc;
          granted_pending[mon_g] = 1'b1;
        end
      end else if (m_report) begin
        check("report_flags", {done, err_nack, err_timeout}, {1'b1, m_nack, m_to});
        check("report_outputs", {busy, cmd_valid, data_in_valid, data_in_last, ch0_ack, ch1_ack},
              6'b100000);
        if (m_nack && exp_nack_cnt < 255) exp_nack_cnt++;
        m_idle = 1'b1;
        m_report = 1'b0;
      end else begin
        mon_e = cyc - m_grant_cyc;
        check("active_outputs", {busy, done, ch0_ack, ch1_ack}, 4'b1000);
        if (i2c_missed_ack) m_nack = 1'b1;
        if (mon_e == T - 1) begin
          check("timeout_valids_dropped", {cmd_valid, data_in_valid, data_in_last}, 0);
          m_to = 1'b1;
          m_report = 1'b1;
          exp_q.delete();
        end else if (m_item == 0) begin
          check("cmd_fields", {cmd_valid, cmd_address, cmd_write_multiple, cmd_stop, data_in_valid},
                {1'b1, 7'h60, 1'b1, 1'b1, 1'b0});
          if (cmd_ready) m_item = 1;
        end else if (m_item <= 3) begin
          check("byte_valids", {cmd_valid, data_in_valid, data_in_last}, {1'b0, 1'b1, m_item == 3});
          check("byte_data", data_in, exp_q[0]);
          if (data_in_ready) begin
            void'(exp_q.pop_front());
            m_item++;
          end
        end else begin
          check("wait_valids", {cmd_valid, data_in_valid, data_in_last}, 0);
          if (!i2c_busy) m_report = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int mode = 0;        // 0 ready, 1 random, 2 five-cycle stalls per byte, 3 cmd_ready held low
  bit nack_b1 = 1'b0;  // pulse missed_ack while the second data byte is offered
  int stall_cnt = 0;

  task automatic tick();
    @(posedge clk_25M);
    #1;
    i2c_missed_ack = 1'b0;
    case (mode)
      0: begin cmd_ready = 1'b1; data_in_ready = 1'b1; i2c_busy = 1'b0; end
      1: begin
        cmd_ready      = ($urandom_range(0, 3) != 0);
        data_in_ready  = ($urandom_range(0, 3) != 0);
        i2c_busy       = ($urandom_range(0, 1) != 0);
        i2c_missed_ack = ($urandom_range(0, 15) == 0);
      end
      2: begin
        cmd_ready = 1'b1; i2c_busy = 1'b0;
        if (data_in_valid) begin
          if (stall_cnt < 5) begin data_in_ready = 1'b0; stall_cnt++; end
          else begin data_in_ready = 1'b1; stall_cnt = 0; end
        end else begin
          data_in_ready = 1'b0;
        end
      end
      default: begin cmd_ready = 1'b0; data_in_ready = 1'b1; i2c_busy = 1'b0; end
    endcase
    if (nack_b1 && data_in_valid && exp_q.size() == 2) i2c_missed_ack = 1'b1;
  endtask

  task automatic request(input int ch, input logic [11:0] v);
    bit found = 1'b0;
    if (ch == 0) begin ch0_req = 1'b1; ch0_value = v; end
    else begin ch1_req = 1'b1; ch1_value = v; end
    for (int i = 0; i < 300; i++) begin
      #1;
      if ((ch == 0) ? ch0_ack : ch1_ack) begin found = 1'b1; break; end
      tick();
    end
    check("ack_within_budget", found, 1);
    tick();
    if (ch == 0) ch0_req = 1'b0; else ch1_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    check("done_within_budget", seen, 1);
    tick();
  endtask

  task automatic run_txn(input int ch, input logic [11:0] v, input int budget);
    request(ch, v);
    wait_done(budget);
  endtask

  task automatic clear_logs();
    g_log.delete();
    byte_log.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    bit found;
    rst_p = 1'b1;
    ch0_req = 1'b0; ch1_req = 1'b0; ch0_value = '0; ch1_value = '0;
    cmd_ready = 1'b0; data_in_ready = 1'b0; i2c_busy = 1'b0; i2c_missed_ack = 1'b0;
    repeat (3) tick();
    rst_p = 1'b0;
    tick();

    // contention: both held for four transactions
    clear_logs();
    ch0_value = 12'h123; ch1_value = 12'h456;
    ch0_req = 1'b1; ch1_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 4; i++) begin
      tick();
      if (done) cnt++;
    end
    ch0_req = 1'b0; ch1_req = 1'b0;
    tick();
    check("contention_txns", cnt, 4);
    check("contention_grant_count", g_log.size(), 4);
    if (g_log.size() == 4)
      check("contention_order", {g_log[0], g_log[1], g_log[2], g_log[3]}, 4'b0101);
    check("contention_byte_count", byte_log.size(), 12);
    if (byte_log.size() == 12)
      check("contention_ch1_bytes", {byte_log[3], byte_log[4], byte_log[5]},
            {9'h008, 9'h004, 9'h156});

    // single write
    clear_logs();
    run_txn(0, 12'hABC, 100);
    check("single_grant", g_log.size(), 1);
    if (byte_log.size() == 3)
      check("single_bytes", {byte_log[0], byte_log[1], byte_log[2]}, {9'h000, 9'h00A, 9'h1BC});
    else check("single_byte_count", byte_log.size(), 3);
    check("single_latency", act_done_cyc - act_grant_cyc, 6);
    check("single_errors", {act_err_nack, act_err_to}, 0);

    // backpressure: five stall cycles per byte
    clear_logs();
    mode = 2; stall_cnt = 0;
    run_txn(1, 12'hF5A, 100);
    mode = 0;
    check("bp_byte_count", byte_log.size(), 3);
    if (byte_log.size() == 3)
      check("bp_bytes", {byte_log[0], byte_log[1], byte_log[2]}, {9'h008, 9'h00F, 9'h15A});
    check("bp_latency", act_done_cyc - act_grant_cyc, 21);

    // NACK during the second byte
    check("nack_count_before", nack_count, 0);
    nack_b1 = 1'b1;
    run_txn(0, 12'h321, 100);
    check("nack_flags", {act_err_nack, act_err_to}, 2'b10);
    check("nack_latency", act_done_cyc - act_grant_cyc, 6);
    check("nack_count_first", nack_count, 1);
    for (int i = 0; i < 300; i++) run_txn(i % 2, 12'($urandom), 100);
    nack_b1 = 1'b0;
    check("nack_count_saturated", nack_count, 255);

    // timeout with the command never accepted
    mode = 3;
    run_txn(1, 12'h0F0, 120);
    mode = 0;
    check("timeout_latency", act_done_cyc - act_grant_cyc, T);
    check("timeout_flags", {act_err_nack, act_err_to}, 2'b01);
    check("timeout_nack_count", nack_count, 255);
    clear_logs();
    run_txn(0, 12'h00F, 100);
    check("after_timeout_latency", act_done_cyc - act_grant_cyc, 6);
    check("after_timeout_flags", {act_err_nack, act_err_to}, 0);
    if (byte_log.size() == 3)
      check("after_timeout_bytes", {byte_log[0], byte_log[1], byte_log[2]},
            {9'h000, 9'h000, 9'h10F});
    else check("after_timeout_byte_count", byte_log.size(), 3);

    // randomized traffic
    granted_pending[0] = 1'b0; granted_pending[1] = 1'b0;
    mode = 1;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (granted_pending[0]) begin
        granted_pending[0] = 1'b0;
        if ($urandom_range(0, 1) != 0) ch0_req = 1'b0; else ch0_value = 12'($urandom);
      end else if (!ch0_req && $urandom_range(0, 7) == 0) begin
        ch0_req = 1'b1; ch0_value = 12'($urandom);
      end
      if (granted_pending[1]) begin
        granted_pending[1] = 1'b0;
        if ($urandom_range(0, 1) != 0) ch1_req = 1'b0; else ch1_value = 12'($urandom);
      end else if (!ch1_req && $urandom_range(0, 7) == 0) begin
        ch1_req = 1'b1; ch1_value = 12'($urandom);
      end
    end
    ch0_req = 1'b0; ch1_req = 1'b0;
    mode = 0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy) begin found = 1'b1; break; end
    end
    check("random_drain_idle", found, 1);
    tick();

    // reset in the middle of the second byte
    mode = 2; stall_cnt = 0;
    request(0, 12'h9C3);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (data_in_valid && exp_q.size() == 2) begin found = 1'b1; break; end
    end
    check("reached_b1", found, 1);
    #2 rst_p = 1'b1;
    #1 check("async_reset_drop", {cmd_valid, data_in_valid, data_in_last, busy}, 0);
    tick();
    rst_p = 1'b0;
    mode = 0;
    clear_logs();
    ch0_value = 12'h111; ch1_value = 12'h222;
    ch0_req = 1'b1; ch1_req = 1'b1;
    #1 check("post_reset_first_grant", {ch0_ack, ch1_ack}, 2'b10);
    tick();
    ch0_req = 1'b0; ch1_req = 1'b0;
    wait_done(100);
    check("post_reset_latency", act_done_cyc - act_grant_cyc, 6);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mcp47feb_dac_sequencer.md
Name: mcp47feb_dac_sequencer

Overview:
- Arbitrates DAC update requests from two requesters (ch0 = DAC0 register, ch1 = DAC1 register) on the MCP47FEB over the shared i2c_master command/data stream interface.
- Each granted request becomes one I2C write_multiple transaction with stop: a command byte, then the 12-bit value as two bytes.
- Replaces the free-running DAC test FSM in controller_test.
- The i2c_master instance is clocked from clk_25M in this integration, so no clock crossing exists.

Parameters:
- DEV_ADDR, 7'h60, I2C 7-bit device address.
- CH0_REG, 5'h00, MCP47FEB register address for ch0.
- CH1_REG, 5'h01, MCP47FEB register address for ch1.
- TIMEOUT, 20000, max clk_25M cycles from grant to completion (width 16).

Ports:
- clk_25M in 1: clock.
- rst_p in 1: reset, asynchronous, active-high.
- ch0_req in 1: ch0 update request, level; held until ch0_ack.
- ch0_value in 12: ch0 DAC code, sampled at grant.
- ch0_ack out 1: 1-cycle pulse at grant of ch0.
- ch1_req in 1: as ch0_req.
- ch1_value in 12: as ch0_value.
- ch1_ack out 1: as ch0_ack.
- cmd_address out 7: to i2c_master.
- cmd_write_multiple out 1: to i2c_master.
- cmd_stop out 1: to i2c_master.
- cmd_start, cmd_read, cmd_write out 1 each: tied 0.
- cmd_valid out 1: command valid.
- cmd_ready in 1: command ready.
- data_in out 8: write byte.
- data_in_valid out 1: write byte valid.
- data_in_ready in 1: write byte ready.
- data_in_last out 1: marks final byte.
- i2c_busy in 1: i2c_master busy.
- i2c_missed_ack in 1: i2c_master missed_ack pulse.
- busy out 1: transaction in progress.
- done out 1: 1-cycle pulse on completion (success, NACK or timeout).
- err_nack out 1: qualifies done, 1 if any NACK occurred during the transaction.
- err_timeout out 1: qualifies done, 1 if the transaction aborted on timeout.
- nack_count out 8: saturating count of NACKed transactions.

Behaviour:
- Reset values: all outputs 0; last_grant=1, so ch0 wins first.
- The reset is asynchronous. Mid-transaction reset drops all valids immediately and returns to IDLE; no partial transfer resumes.
- Handshakes use valid/ready. A transfer occurs on an edge with valid&&ready. Valid, data and last stay stable until that transfer. Valid drops the cycle after the transfer unless the next byte follows.
- States:
  - IDLE: if any req is high, grant by round-robin. If both are high, grant the channel opposite last_grant. Latch the value and register, pulse the ack, update last_grant, clear the timeout counter and NACK flag, then go to CMD. With no req, stay in IDLE.
  - CMD: cmd_valid=1, cmd_address=DEV_ADDR, cmd_write_multiple=1, cmd_stop=1. Transfer -> B0.
  - B0: data_in={reg[4:0],2'b00,1'b0}, last=0. Transfer -> B1.
  - B1: data_in={4'b0,value[11:8]}, last=0. Transfer -> B2.
  - B2: data_in=value[7:0], last=1. Transfer -> WAIT.
  - WAIT: when i2c_busy==0, go to REPORT.
  - REPORT: pulse done with err_nack and err_timeout valid for that cycle. If err_nack, nack_count += 1, saturating at 255. Go to IDLE.
- Transaction latency: at least 6 cycles from grant to done (CMD, B0, B1, B2, WAIT, REPORT), even with ready always high and busy low.
- Earliest next grant is the cycle after REPORT.
- busy=1 in every state except IDLE.
- NACK: an i2c_missed_ack pulse in any non-IDLE state sets the sticky NACK flag. The sequence still runs to completion; i2c_master handles the stop.
- Timeout: the counter increments in every non-IDLE state. At TIMEOUT-1, drop all valids and last, then go to REPORT with err_timeout=1. nack_count is unchanged unless the NACK flag is also set.
- A req deasserted before grant is simply not served. A req still high after ack is treated as a new request.
- Acks are never pulsed outside IDLE.

Test Plan:
- Single write: ch0_req with 12'hABC, all readies high -> ch0_ack 1 cycle; cmd address 7'h60 with write_multiple=1, stop=1; bytes 8'h00, 8'h0A, 8'hBC, with last only on 8'hBC; done with both errors 0.
- Contention: ch0 and ch1 held high with 12'h123 / 12'h456 for 4 transactions -> grants ch0, ch1, ch0, ch1; ch1 command byte is 8'h08.
- Backpressure: data_in_ready low for 5 cycles on each byte -> data and valid stable while stalled; exactly 3 byte transfers; no duplicate or dropped byte.
- NACK: i2c_missed_ack pulsed during B1 -> sequence completes; done with err_nack=1; nack_count 0->1. After 300 forced NACKs, nack_count stays at 255.
- Timeout: TIMEOUT=50 with cmd_ready held low -> cmd_valid drops; done with err_timeout=1 exactly 50 cycles after grant; next req is served normally.
- Reset mid-B1: rst_p asserted -> valids and busy go to 0 asynchronously; after release, ch0 wins the first grant.
